// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush,
// optional skid entry and a saturating count of squashed beats.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic              accept;
    logic              emit;
    logic [1:0]        squashed;
    logic [CNT_W:0]    cnt_sum;

    // With a skid entry, in_ready depends only on registered state (plus flush),
    // so out_ready never reaches the upstream ready path.
    always_comb begin
        in_ready = 1'b0;
        if (SKID != 0) begin
            in_ready = ~skid_valid & ~flush;
        end else begin
            in_ready = (~main_valid | out_ready) & ~flush;
        end
        accept   = in_valid & in_ready;
        emit     = main_valid & out_ready;
        squashed = {1'b0, main_valid} + {1'b0, skid_valid} - {1'b0, emit};
        cnt_sum  = {1'b0, flush_cnt} + (CNT_W+1)'(squashed);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else if (SKID != 0) begin
            if (skid_valid) begin
                // Skid full means upstream is blocked; drain skid into main.
                if (emit) begin
                    main_valid <= 1'b1;
                    main_data  <= skid_data;
                    main_ctrl  <= skid_ctrl;
                    skid_valid <= 1'b0;
                    skid_ctrl  <= '0;
                end
            end else if (!main_valid || emit) begin
                if (accept) begin
                    main_valid <= 1'b1;
                    main_data  <= in_data;
                    main_ctrl  <= in_ctrl;
                end else if (emit) begin
                    main_valid <= 1'b0;
                    main_ctrl  <= '0;
                end
            end else if (accept) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
                skid_ctrl  <= in_ctrl;
            end
        end else begin
            if (accept) begin
                main_valid <= 1'b1;
                main_data  <= in_data;
                main_ctrl  <= in_ctrl;
            end else if (emit) begin
                main_valid <= 1'b0;
                main_ctrl  <= '0;
            end
        end
    end

    // A beat emitting in the flush cycle completes normally and is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt <= '0;
        end else if (flush) begin
            if (cnt_sum[CNT_W]) begin
                flush_cnt <= '1;
            end else begin
                flush_cnt <= cnt_sum[CNT_W-1:0];
            end
        end
    end

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: SKID=1 (8-bit and 2-bit counter) and SKID=0
// instances share one stimulus stream; each check is an immediate assertion.
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic [15:0] in_ctrl;
    logic        flush;
    logic        out_ready;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data;
    logic [15:0] a_out_ctrl;
    logic [7:0]  a_flush_cnt;

    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [15:0] b_out_ctrl;
    logic [7:0]  b_flush_cnt;

    logic        c_in_ready, c_out_valid;
    logic [31:0] c_out_data;
    logic [15:0] c_out_ctrl;
    logic [1:0]  c_flush_cnt;

    int total;
    int bad;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(1), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_ctrl(a_out_ctrl), .flush_cnt(a_flush_cnt)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(0), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_ctrl(b_out_ctrl), .flush_cnt(b_flush_cnt)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(1), .CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
        .out_ctrl(c_out_ctrl), .flush_cnt(c_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [15:0] c,
                                 input logic ordy, input logic fl, input logic rst);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
    endtask

    // Inputs change and outputs are sampled only at the falling edge.
    task automatic waitCycle();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Reset held two cycles with a beat offered.
        applyStimulus(1'b1, 32'h55, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        waitCycle();
        waitCycle();
        applyStimulus(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("rst_a_valid", 32'(a_out_valid), 32'd0);
        checkOutput("rst_a_ctrl",  32'(a_out_ctrl),  32'd0);
        checkOutput("rst_a_data",  a_out_data,       32'd0);
        checkOutput("rst_a_cnt",   32'(a_flush_cnt), 32'd0);
        checkOutput("rst_a_ready", 32'(a_in_ready),  32'd1);
        checkOutput("rst_b_valid", 32'(b_out_valid), 32'd0);
        checkOutput("rst_b_ready", 32'(b_in_ready),  32'd1);
        checkOutput("rst_c_cnt",   32'(c_flush_cnt), 32'd0);

        // Back-to-back streaming, one-cycle latency, no gaps.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 32'(i), 16'hFFFF, 1'b1, 1'b0, 1'b0);
            waitCycle();
            checkOutput("str_a_valid", 32'(a_out_valid), 32'd1);
            checkOutput("str_a_data",  a_out_data,       32'(i));
            checkOutput("str_a_ctrl",  32'(a_out_ctrl),  32'hFFFF);
            checkOutput("str_b_valid", 32'(b_out_valid), 32'd1);
            checkOutput("str_b_data",  b_out_data,       32'(i));
        end
        applyStimulus(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        waitCycle();
        checkOutput("str_end_a_valid", 32'(a_out_valid), 32'd0);
        checkOutput("str_end_a_ctrl",  32'(a_out_ctrl),  32'd0);
        checkOutput("str_end_a_data",  a_out_data,       32'h8);
        checkOutput("str_end_b_valid", 32'(b_out_valid), 32'd0);

        // Stall: A,B,C offered with out_ready low.
        applyStimulus(1'b1, 32'hA, 16'h1234, 1'b0, 1'b0, 1'b0);
        waitCycle();
        checkOutput("stl1_a_data",  a_out_data,      32'hA);
        checkOutput("stl1_a_ready", 32'(a_in_ready), 32'd1);
        checkOutput("stl1_b_ready", 32'(b_in_ready), 32'd0);
        applyStimulus(1'b1, 32'hB, 16'h1234, 1'b0, 1'b0, 1'b0);
        waitCycle();
        checkOutput("stl2_a_data",  a_out_data,      32'hA);
        checkOutput("stl2_a_ready", 32'(a_in_ready), 32'd0);
        checkOutput("stl2_b_data",  b_out_data,      32'hA);
        applyStimulus(1'b1, 32'hC, 16'h1234, 1'b0, 1'b0, 1'b0);
        waitCycle();
        checkOutput("stl3_a_valid", 32'(a_out_valid), 32'd1);
        checkOutput("stl3_a_data",  a_out_data,       32'hA);
        checkOutput("stl3_a_ready", 32'(a_in_ready),  32'd0);
        applyStimulus(1'b1, 32'hC, 16'h1234, 1'b1, 1'b0, 1'b0);
        waitCycle();
        checkOutput("stl4_a_data",  a_out_data,      32'hB);
        checkOutput("stl4_a_ctrl",  32'(a_out_ctrl), 32'h1234);
        checkOutput("stl4_a_ready", 32'(a_in_ready), 32'd1);
        checkOutput("stl4_b_data",  b_out_data,      32'hC);
        waitCycle();
        checkOutput("stl5_a_data",  a_out_data,       32'hC);
        checkOutput("stl5_a_valid", 32'(a_out_valid), 32'd1);
        applyStimulus(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        waitCycle();
        checkOutput("stl6_a_valid", 32'(a_out_valid), 32'd0);
        checkOutput("stl6_a_ctrl",  32'(a_out_ctrl),  32'd0);
        checkOutput("stl6_b_valid", 32'(b_out_valid), 32'd0);

        // Flush on an empty stage: ready drops, offered beat dropped, count unchanged.
        applyStimulus(1'b1, 32'h77, 16'h0F0F, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("fle_a_ready", 32'(a_in_ready), 32'd0);
        checkOutput("fle_b_ready", 32'(b_in_ready), 32'd0);
        waitCycle();
        applyStimulus(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("fle_a_valid", 32'(a_out_valid), 32'd0);
        checkOutput("fle_b_valid", 32'(b_out_valid), 32'd0);
        checkOutput("fle_a_cnt",   32'(a_flush_cnt), 32'd0);

        // Flush with main and skid both held (three rounds; 2-bit counter saturates).
        for (int r = 1; r <= 3; r++) begin
            applyStimulus(1'b1, 32'h11, 16'h0F0F, 1'b0, 1'b0, 1'b0);
            waitCycle();
            applyStimulus(1'b1, 32'h22, 16'h0F0F, 1'b0, 1'b0, 1'b0);
            waitCycle();
            checkOutput("fl_a_held", a_out_data, 32'h11);
            applyStimulus(1'b1, 32'h33, 16'h0F0F, 1'b0, 1'b1, 1'b0);
            waitCycle();
            applyStimulus(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0);
            checkOutput("fl_a_valid", 32'(a_out_valid), 32'd0);
            checkOutput("fl_a_ctrl",  32'(a_out_ctrl),  32'd0);
            checkOutput("fl_a_data",  a_out_data,       32'd0);
            checkOutput("fl_a_cnt",   32'(a_flush_cnt), 32'(2 * r));
            checkOutput("fl_b_cnt",   32'(b_flush_cnt), 32'(r));
            checkOutput("fl_c_cnt",   32'(c_flush_cnt), (r == 1) ? 32'd2 : 32'd3);
            waitCycle();
            checkOutput("fl_a_nobeat", 32'(a_out_valid), 32'd0);
            checkOutput("fl_b_nobeat", 32'(b_out_valid), 32'd0);
        end

        // Flush while the head emits: only the skid beat is counted.
        applyStimulus(1'b1, 32'h11, 16'h0F0F, 1'b0, 1'b0, 1'b0);
        waitCycle();
        applyStimulus(1'b1, 32'h22, 16'h0F0F, 1'b0, 1'b0, 1'b0);
        waitCycle();
        applyStimulus(1'b1, 32'h44, 16'h0F0F, 1'b1, 1'b1, 1'b0);
        waitCycle();
        applyStimulus(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("fle_emit_a_cnt",   32'(a_flush_cnt), 32'd7);
        checkOutput("fle_emit_b_cnt",   32'(b_flush_cnt), 32'd3);
        checkOutput("fle_emit_c_cnt",   32'(c_flush_cnt), 32'd3);
        checkOutput("fle_emit_a_valid", 32'(a_out_valid), 32'd0);

        // Reset with both entries full.
        applyStimulus(1'b1, 32'h11, 16'h0F0F, 1'b0, 1'b0, 1'b0);
        waitCycle();
        applyStimulus(1'b1, 32'h22, 16'h0F0F, 1'b0, 1'b0, 1'b0);
        waitCycle();
        checkOutput("rms_a_full", 32'(a_in_ready), 32'd0);
        applyStimulus(1'b1, 32'h66, 16'h0F0F, 1'b0, 1'b0, 1'b1);
        waitCycle();
        applyStimulus(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("rms_a_valid", 32'(a_out_valid), 32'd0);
        checkOutput("rms_a_data",  a_out_data,       32'd0);
        checkOutput("rms_a_cnt",   32'(a_flush_cnt), 32'd0);
        checkOutput("rms_a_ready", 32'(a_in_ready),  32'd1);
        checkOutput("rms_b_cnt",   32'(b_flush_cnt), 32'd0);
        checkOutput("rms_c_cnt",   32'(c_flush_cnt), 32'd0);
        waitCycle();
        checkOutput("rms_a_nobeat", 32'(a_out_valid), 32'd0);
        checkOutput("rms_b_nobeat", 32'(b_out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
